hazard_scoreboard: RTL and testbench

// - Parametrised stall/forward unit for the D stage of the in-order MIPS pipeline.
// - Keeps a shift-register scoreboard of in-flight writers, one entry per stage after D:

---
 rtl/hazard_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall and forward-select unit for the D stage of the
// in-order MIPS pipeline. A shift-register scoreboard records the in-flight
// writers, one entry per stage after D (entry 1 = E, entry 2 = M, entry 3 = W).
// Each entry holds the destination register and its remaining Tnew. The D-stage
// Tuse of rs/rt is compared against the youngest matching entry.
// Optional feature: define HAZARD_MD_BUSY_EN to track multiply/divide occupancy
// of the HI/LO unit. Without it md_busy is tied low and the md inputs are ignored.
module hazard_scoreboard #(
  parameter int STAGES      = 3,
  parameter int REG_AW      = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             d_valid,
  input  logic [REG_AW-1:0]                d_rs,
  input  logic [REG_AW-1:0]                d_rt,
  input  logic [T_W-1:0]                   d_tuse_rs,
  input  logic [T_W-1:0]                   d_tuse_rt,
  input  logic [REG_AW-1:0]                d_wreg,
  input  logic [T_W-1:0]                   d_tnew,
  input  logic                             d_ismd,
  input  logic                             d_md_start,
  input  logic                             d_md_div,
  output logic                             stall,
  output logic [$clog2(STAGES+1)-1:0]      fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0]      fwd_rt_sel,
  output logic                             md_busy
);

  localparam int SEL_W  = $clog2(STAGES + 1);
  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);
  localparam logic [T_W-1:0] NOUSE = {T_W{1'b1}};

  // Scoreboard storage; array index k holds pipeline entry k+1
  logic [STAGES-1:0] entValid_q, entValid_d;
  logic [REG_AW-1:0] entWreg_q [STAGES];
  logic [REG_AW-1:0] entWreg_d [STAGES];
  logic [T_W-1:0]    entTnew_q [STAGES];
  logic [T_W-1:0]    entTnew_d [STAGES];

  logic             rsHit, rtHit;
  logic [SEL_W-1:0] rsEntry, rtEntry;
  logic [T_W-1:0]   rsTnew, rtTnew;
  logic             rsStall, rtStall, mdStall;

  // Tnew counts down once per stage advance and never wraps below zero
  function automatic logic [T_W-1:0] satDec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Shift the scoreboard down one stage; entry 1 takes the D writer only when D issues
  always_comb begin
    entValid_d   = '0;
    entWreg_d[0] = '0;
    entTnew_d[0] = '0;
    if (d_valid && !stall && (d_wreg != '0)) begin
      entValid_d[0] = 1'b1;
      entWreg_d[0]  = d_wreg;
      entTnew_d[0]  = d_tnew;
    end
    for (int k = 1; k < STAGES; k++) begin
      entValid_d[k] = entValid_q[k-1];
      entWreg_d[k]  = entWreg_q[k-1];
      entTnew_d[k]  = satDec(entTnew_q[k-1]);
    end
  end

  // Scoreboard register; downstream entries advance even while D is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      entValid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        entWreg_q[k] <= '0;
        entTnew_q[k] <= '0;
      end
    end else begin
      entValid_q <= entValid_d;
      for (int k = 0; k < STAGES; k++) begin
        entWreg_q[k] <= entWreg_d[k];
        entTnew_q[k] <= entTnew_d[k];
      end
    end
  end

  // Youngest matching writer for rs: scanning old-to-young lets the lowest entry win
  always_comb begin
    rsHit   = 1'b0;
    rsEntry = '0;
    rsTnew  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if ((d_tuse_rs != NOUSE) && (d_rs != '0) && entValid_q[k] && (entWreg_q[k] == d_rs)) begin
        rsHit   = 1'b1;
        rsEntry = SEL_W'(k + 1);
        rsTnew  = entTnew_q[k];
      end
    end
  end

  // Youngest matching writer for rt, same rules as rs
  always_comb begin
    rtHit   = 1'b0;
    rtEntry = '0;
    rtTnew  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if ((d_tuse_rt != NOUSE) && (d_rt != '0) && entValid_q[k] && (entWreg_q[k] == d_rt)) begin
        rtHit   = 1'b1;
        rtEntry = SEL_W'(k + 1);
        rtTnew  = entTnew_q[k];
      end
    end
  end

  // Stall when the value is not ready by Tuse; forward only from an entry whose result is final
  always_comb begin
    rsStall    = rsHit && (rsTnew > d_tuse_rs);
    rtStall    = rtHit && (rtTnew > d_tuse_rt);
    stall      = d_valid && (rsStall || rtStall || mdStall);
    fwd_rs_sel = (rsHit && (rsTnew == '0)) ? rsEntry : '0;
    fwd_rt_sel = (rtHit && (rtTnew == '0)) ? rtEntry : '0;
  end

`ifdef HAZARD_MD_BUSY_EN
  logic [CNT_W-1:0] mdCount_q, mdCount_d;

  // Busy counter: a start reloads it, otherwise it drains to zero; starts while busy are held off by the stall
  always_comb begin
    mdCount_d = mdCount_q;
    if (d_valid && d_md_start && !stall) begin
      mdCount_d = d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (mdCount_q != '0) begin
      mdCount_d = mdCount_q - 1'b1;
    end
  end

  // Busy counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      mdCount_q <= '0;
    end else begin
      mdCount_q <= mdCount_d;
    end
  end

  assign md_busy = (mdCount_q != '0);
  assign mdStall = d_ismd && md_busy;
`else
  logic [CNT_W-1:0] md_unused_cnt;
  logic             md_unused_in;

  assign md_unused_cnt = '0;
  assign md_unused_in  = ^{d_ismd, d_md_start, d_md_div};
  assign md_busy       = 1'b0;
  assign mdStall       = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven bench for hazard_scoreboard. Each record
// is one D-stage cycle with its expected outputs; expectations are queued when
// the record is driven and popped when the outputs are sampled mid-cycle.
module tb_hazard_scoreboard;

  localparam logic [1:0] NU = 2'b11;
`ifdef HAZARD_MD_BUSY_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wreg;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_ismd, d_md_start, d_md_div;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic       md_busy;

  typedef struct {
    string      name;
    logic       valid;
    logic [4:0] rs;
    logic [1:0] tuseRs;
    logic [4:0] rt;
    logic [1:0] tuseRt;
    logic [4:0] wreg;
    logic [1:0] tnew;
    logic       ismd;
    logic       mdStart;
    logic       mdDiv;
    logic       expStall;
    logic [1:0] expRsSel;
    logic [1:0] expRtSel;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int   nCompared;
  int   nMismatched;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wreg     (d_wreg),
    .d_tnew     (d_tnew),
    .d_ismd     (d_ismd),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input string name, input logic valid,
                              input logic [4:0] rs, input logic [1:0] tuseRs,
                              input logic [4:0] rt, input logic [1:0] tuseRt,
                              input logic [4:0] wreg, input logic [1:0] tnew,
                              input logic ismd, input logic mdStart, input logic mdDiv,
                              input logic eStall, input logic [1:0] eRs,
                              input logic [1:0] eRt, input logic eBusy);
    vec_t v;
    v.name = name; v.valid = valid; v.rs = rs; v.tuseRs = tuseRs;
    v.rt = rt; v.tuseRt = tuseRt; v.wreg = wreg; v.tnew = tnew;
    v.ismd = ismd; v.mdStart = mdStart; v.mdDiv = mdDiv;
    v.expStall = eStall; v.expRsSel = eRs; v.expRtSel = eRt; v.expBusy = eBusy;
    return v;
  endfunction

  function automatic vec_t idle(input string name, input logic eBusy);
    return mk(name, 1'b0, 5'd0, NU, 5'd0, NU, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0,
              1'b0, 2'd0, 2'd0, eBusy);
  endfunction

  task automatic checkField(input string name, input string field,
                            input logic [1:0] act, input logic [1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
    end
  endtask

  // Sample mid-cycle and compare against the oldest queued expectation
  task automatic checkOutput();
    vec_t e;
    @(negedge clk);
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL scoreboard: expectation queue empty");
    end else begin
      e = expQ.pop_front();
      checkField(e.name, "stall",      {1'b0, stall},   {1'b0, e.expStall});
      checkField(e.name, "fwd_rs_sel", fwd_rs_sel,      e.expRsSel);
      checkField(e.name, "fwd_rt_sel", fwd_rt_sel,      e.expRtSel);
      checkField(e.name, "md_busy",    {1'b0, md_busy}, {1'b0, e.expBusy});
    end
  endtask

  // Drive one D-stage cycle (called at posedge+1), check it, advance to next posedge+1
  task automatic applyStimulus(input vec_t v);
    d_valid = v.valid; d_rs = v.rs; d_tuse_rs = v.tuseRs;
    d_rt = v.rt; d_tuse_rt = v.tuseRt; d_wreg = v.wreg; d_tnew = v.tnew;
    d_ismd = v.ismd; d_md_start = v.mdStart; d_md_div = v.mdDiv;
    expQ.push_back(v);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(idle("drain", 1'b0));
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    reset = 1'b1;
    d_valid = 1'b0; d_rs = '0; d_rt = '0; d_wreg = '0; d_tnew = '0;
    d_tuse_rs = NU; d_tuse_rt = NU; d_ismd = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;

    // Vector table: name, valid, rs, tuseRs, rt, tuseRt, wreg, tnew, ismd, start, div | stall, rsSel, rtSel, busy
    vecs.push_back(idle("after_reset", 1'b0));
    // lw $8 then beq $8: two stall cycles, then forward from W
    vecs.push_back(mk("lw8",        1, 0, NU, 0, NU, 8, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("beq8_st1",   1, 8, 0,  0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("beq8_st2",   1, 8, 0,  0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("beq8_fwd",   1, 8, 0,  0, 0,  0, 0, 0, 0, 0, 0, 3, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle("gap1", 0));
    // ori $9 then add reading $9 at Tuse 1: no stall, no forward yet
    vecs.push_back(mk("ori9",       1, 0, NU, 0, NU, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("add_rt9",    1, 0, 1,  9, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle("gap2", 0));
    // ori $9 then beq reading $9 at Tuse 0: one stall, then forward from M
    vecs.push_back(mk("ori9b",      1, 0, NU, 0, NU, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("beq9_st",    1, 0, 0,  9, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("beq9_fwd",   1, 0, 0,  9, 0,  0, 0, 0, 0, 0, 0, 0, 2, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle("gap3", 0));
    // Writer to $0 never matches
    vecs.push_back(mk("wr0",        1, 0, NU, 0, NU, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("beq0",       1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle("gap4", 0));
    // addi $3 then lw $3: youngest (lw) entry governs
    vecs.push_back(mk("addi3",      1, 0, NU, 0, NU, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lw3",        1, 0, NU, 0, NU, 3, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("beq3_st1",   1, 3, 0,  0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("beq3_st2",   1, 3, 0,  0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("beq3_fwd",   1, 3, 0,  0, 0,  0, 0, 0, 0, 0, 0, 3, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle("gap5", 0));
    // Unused operand (NOUSE) never stalls even on a pending writer
    vecs.push_back(mk("wr5",        1, 0, NU, 0, NU, 5, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("nouse5",     1, 5, NU, 0, NU, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle("gap6", 0));
    // Ready result forwards from E, then from M, on both operands
    vecs.push_back(mk("wr6",        1, 0, NU, 0, NU, 6, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd6_e",      1, 6, 1,  6, 1,  0, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk("rd6_m",      1, 6, 0,  6, 0,  0, 0, 0, 0, 0, 0, 2, 2, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle("gap7", 0));
    // Boundary tnew == Tuse: no stall, not yet forwarded
    vecs.push_back(mk("wr12",       1, 0, NU, 0, NU, 12, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd12_eq",    1, 12, 2, 0, NU, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle("gap8", 0));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // div then mfhi: mfhi held off while the HI/LO unit is busy
    applyStimulus(mk("div", 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 11; i++) begin
      logic busy;
      busy = MD_ON && (i <= 10);
      applyStimulus(mk($sformatf("mfhi_div_%0d", i), 1, 0, NU, 0, NU, 2, 1, 1, 0, 0,
                       busy, 0, 0, busy));
      if (!busy) break;
    end
    drain(3);

    // mult then mfhi: shorter occupancy
    applyStimulus(mk("mult", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++) begin
      logic busy;
      busy = MD_ON && (i <= 5);
      applyStimulus(mk($sformatf("mfhi_mult_%0d", i), 1, 0, NU, 0, NU, 2, 1, 1, 0, 0,
                       busy, 0, 0, busy));
      if (!busy) break;
    end
    drain(3);

    // Reset in the middle of a load-use stall with the md unit busy
    applyStimulus(mk("rst_div", 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    applyStimulus(mk("rst_lw8", 1, 0, NU, 0, NU, 8, 2, 0, 0, 0, 0, 0, 0, MD_ON));
    d_valid = 1'b1; d_rs = 5'd8; d_tuse_rs = 2'd0; d_rt = 5'd0; d_tuse_rt = 2'd0;
    d_wreg = 5'd0; d_tnew = 2'd0; d_ismd = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
    expQ.push_back(mk("rst_beq_st", 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_ON));
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(mk("rst_beq_after", 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk("rst_ismd_after", 1, 0, NU, 0, NU, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    if (expQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL scoreboard: %0d expectations left unchecked", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
